// File: rtl/mcpu_uart_rx.sv
// 8N1 UART receiver: synchronizes the serial line, samples each bit at mid-point
// and hands received bytes to the consumer through a valid/ready holding register.
module mcpu_uart_rx #(
  parameter int CLKS_PER_BIT = 1085,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clkrst_core_clk,
  input  logic       clkrst_core_rst,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam int              CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   CNT_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic [7:0]        data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              frame_err_reg, frame_err_next;
  logic              overrun_reg, overrun_next;
  logic              complete;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic              rxs;

  // Synchronizer presets to the idle level so reset never fakes a start bit.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      always_ff @(posedge clkrst_core_clk) begin
        if (clkrst_core_rst) begin
          sync_reg[gi] <= 1'b1;
        end else begin
          sync_reg[gi] <= (gi == 0) ? uart_rx : sync_reg[(gi == 0) ? 0 : gi - 1];
        end
      end
    end
  endgenerate

  assign rxs = sync_reg[SYNC_STAGES-1];

  always_ff @(posedge clkrst_core_clk) begin
    if (clkrst_core_rst) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      bit_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_reg       <= bit_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
      overrun_reg   <= overrun_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_next       = bit_reg;
    shift_next     = shift_reg;
    frame_err_next = 1'b0;
    complete       = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rxs) state_next = START;
      end
      START: begin
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == CNT_MID) begin
          // A start bit that is gone by mid-bit was a glitch.
          state_next = rxs ? IDLE : DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (cnt_reg == CNT_TICK) begin
          cnt_next            = '0;
          shift_next[bit_reg] = rxs;
          bit_next            = bit_reg + 3'd1;
          if (bit_reg == 3'd7) state_next = STOP;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      STOP: begin
        if (cnt_reg == CNT_TICK) begin
          if (rxs) begin
            complete   = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = WAIT_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      WAIT_IDLE: begin
        if (rxs) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (state_next != state_reg) cnt_next = '0;
  end

  // Holding register: a drain on the completion edge makes room for the new byte.
  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = 1'b0;
    if (complete) begin
      if (!valid_reg || rx_ready) begin
        data_next  = shift_reg;
        valid_next = 1'b1;
      end else begin
        overrun_next = 1'b1;
      end
    end else if (rx_ready) begin
      valid_next = 1'b0;
    end
  end

  assign rx_data      = data_reg;
  assign rx_valid     = valid_reg;
  assign rx_frame_err = frame_err_reg;
  assign rx_overrun   = overrun_reg;
  assign rx_busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mcpu_uart_rx.sv
// Directed-plus-random bench for mcpu_uart_rx: drives serial frames and checks
// received bytes, pulses and latency against a queue-based reference.
module tb_mcpu_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       line_a, line_b;
  logic       ready_a, ready_b;
  logic [7:0] data_a, data_b;
  logic       valid_a, valid_b;
  logic       fe_a, fe_b, ov_a, ov_b, busy_a, busy_b;

  always #5 clk = ~clk;

  mcpu_uart_rx #(.CLKS_PER_BIT(8), .SYNC_STAGES(2)) dut_a (
    .clkrst_core_clk(clk), .clkrst_core_rst(rst), .uart_rx(line_a),
    .rx_data(data_a), .rx_valid(valid_a), .rx_ready(ready_a),
    .rx_frame_err(fe_a), .rx_overrun(ov_a), .rx_busy(busy_a));

  mcpu_uart_rx #(.CLKS_PER_BIT(1085), .SYNC_STAGES(2)) dut_b (
    .clkrst_core_clk(clk), .clkrst_core_rst(rst), .uart_rx(line_b),
    .rx_data(data_b), .rx_valid(valid_b), .rx_ready(ready_b),
    .rx_frame_err(fe_b), .rx_overrun(ov_b), .rx_busy(busy_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation counters, sampled mid-cycle.
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] got_b_q[$];
  int rise_cnt = 0, rise_cyc = 0, fall_cnt = 0, hi_cnt = 0;
  int fe_cnt = 0, ov_cnt = 0, both_cnt = 0, busy_low_cnt = 0;
  int rise_b_cnt = 0, rise_b_cyc = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;

  always @(negedge clk) begin
    if (valid_a && ready_a) got_q.push_back(data_a);
    if (valid_a && !prev_a) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (!valid_a && prev_a) fall_cnt <= fall_cnt + 1;
    if (valid_a) hi_cnt <= hi_cnt + 1;
    if (fe_a) fe_cnt <= fe_cnt + 1;
    if (ov_a) ov_cnt <= ov_cnt + 1;
    if ((fe_a && ov_a) || (fe_b && ov_b)) both_cnt <= both_cnt + 1;
    if (!busy_a) busy_low_cnt <= busy_low_cnt + 1;
    prev_a <= valid_a;
    if (valid_b && ready_b) got_b_q.push_back(data_b);
    if (valid_b && !prev_b) begin
      rise_b_cnt <= rise_b_cnt + 1;
      rise_b_cyc <= cyc;
    end
    prev_b <= valid_b;
  end

  int checks = 0;
  int errors = 0;
  int fall_cyc = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_range(input string tag, input int got, input int lo, input int hi);
    checks++;
    assert (got >= lo && got <= hi) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, got, lo, hi);
    end
  endtask

  task automatic cyc_wait(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One 8N1 frame: start, 8 data bits LSB first, stop (stop level selectable).
  task automatic send(input bit sel_b, input logic [7:0] d, input logic stop);
    int         cpb;
    logic [9:0] fr;
    cpb      = sel_b ? 1085 : 8;
    fr       = {stop, d, 1'b0};
    fall_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      if (sel_b) line_b = fr[i];
      else       line_a = fr[i];
      cyc_wait(cpb);
    end
  endtask

  task automatic check_queue(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int s_rise, s_hi, s_fe, s_ov, s_busy, s_fall;
    logic [7:0] rb;

    rst = 1'b1; line_a = 1'b1; line_b = 1'b1; ready_a = 1'b0; ready_b = 1'b0;
    cyc_wait(5);
    chk("rst_valid", valid_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_data", data_a, 0);
    chk("rst_fe", fe_a, 0);
    chk("rst_ov", ov_a, 0);

    // 1: idle line stays quiet
    rst = 1'b0;
    s_busy = busy_low_cnt;
    cyc_wait(500);
    chk("idle_rise", rise_cnt, 0);
    chk("idle_fe", fe_cnt, 0);
    chk("idle_ov", ov_cnt, 0);
    chk("idle_busy_low", busy_low_cnt - s_busy, 500);

    // 2: single frame, latency, back-to-back, random bytes
    ready_a = 1'b1;
    s_rise = rise_cnt; s_hi = hi_cnt;
    exp_q.push_back(8'hA5);
    send(0, 8'hA5, 1'b1);
    cyc_wait(20);
    chk("a5_rises", rise_cnt - s_rise, 1);
    chk("a5_hi_cycles", hi_cnt - s_hi, 1);
    chk_range("a5_latency", rise_cyc - fall_cyc, 78, 80);
    check_queue("a5");
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(0, 8'h00, 1'b1);
    send(0, 8'hFF, 1'b1);
    cyc_wait(20);
    check_queue("b2b");
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      exp_q.push_back(rb);
      send(0, rb, 1'b1);
    end
    cyc_wait(20);
    check_queue("rand");

    // 3: short glitch is rejected
    s_rise = rise_cnt;
    line_a = 1'b0;
    cyc_wait(2);
    line_a = 1'b1;
    cyc_wait(6);
    chk("glitch_busy", busy_a, 0);
    chk("glitch_rise", rise_cnt - s_rise, 0);
    exp_q.push_back(8'h5A);
    send(0, 8'h5A, 1'b1);
    cyc_wait(20);
    check_queue("after_glitch");

    // 4: framing error followed by a held-low line
    s_fe = fe_cnt; s_rise = rise_cnt;
    send(0, 8'h3C, 1'b0);
    s_busy = busy_low_cnt;
    cyc_wait(40);
    chk("fe_pulses", fe_cnt - s_fe, 1);
    chk("fe_busy_low", busy_low_cnt - s_busy, 0);
    chk("fe_busy_now", busy_a, 1);
    chk("fe_rise", rise_cnt - s_rise, 0);
    line_a = 1'b1;
    cyc_wait(10);
    chk("fe_recover_busy", busy_a, 0);
    exp_q.push_back(8'h55);
    send(0, 8'h55, 1'b1);
    cyc_wait(20);
    check_queue("after_fe");
    chk("fe_total", fe_cnt - s_fe, 1);

    // 5: overrun while full, then drain on the exact completion edge
    ready_a = 1'b0;
    s_ov = ov_cnt;
    send(0, 8'h11, 1'b1);
    send(0, 8'h22, 1'b1);
    cyc_wait(5);
    chk("ovr_pulses", ov_cnt - s_ov, 1);
    chk("ovr_valid", valid_a, 1);
    chk("ovr_data_held", data_a, 8'h11);
    ready_a = 1'b1;
    cyc_wait(1);
    ready_a = 1'b0;
    cyc_wait(1);
    chk("ovr_drain_valid", valid_a, 0);
    exp_q.push_back(8'h11);
    check_queue("ovr_drain");
    send(0, 8'h33, 1'b1);
    cyc_wait(5);
    chk("hold33_data", data_a, 8'h33);
    s_ov = ov_cnt; s_fall = fall_cnt;
    rb = 8'($urandom_range(1, 255));
    fork
      send(0, rb, 1'b1);
      begin
        cyc_wait(1);
        while (cyc < fall_cyc + 78) cyc_wait(1);
        ready_a = 1'b1;
        cyc_wait(1);
        ready_a = 1'b0;
      end
    join
    chk("edge_drain_valid", valid_a, 1);
    chk("edge_drain_data", data_a, rb);
    chk("edge_drain_ov", ov_cnt - s_ov, 0);
    chk("edge_drain_nofall", fall_cnt - s_fall, 0);
    exp_q.push_back(8'h33);
    check_queue("edge_drain");

    // 6: reset mid-frame (during data bit 3), then recovery
    line_a = 1'b0;
    cyc_wait(8);
    for (int i = 0; i < 3; i++) begin
      line_a = i[0];
      cyc_wait(8);
    end
    line_a = 1'b1;
    cyc_wait(4);
    rst = 1'b1;
    cyc_wait(1);
    chk("midrst_valid", valid_a, 0);
    chk("midrst_data", data_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_fe", fe_a, 0);
    chk("midrst_ov", ov_a, 0);
    rst = 1'b0;
    line_a = 1'b1;
    got_q.delete();
    cyc_wait(20);
    ready_a = 1'b1;
    exp_q.push_back(8'hC3);
    send(0, 8'hC3, 1'b1);
    cyc_wait(20);
    check_queue("post_rst");

    // Full-rate divider
    ready_b = 1'b1;
    s_rise = rise_b_cnt;
    send(1, 8'h7E, 1'b1);
    cyc_wait(30);
    chk("slow_rises", rise_b_cnt - s_rise, 1);
    chk_range("slow_latency", rise_b_cyc - fall_cyc, 10309, 10311);
    chk("slow_count", got_b_q.size(), 1);
    if (got_b_q.size() > 0) chk("slow_byte", got_b_q[0], 8'h7E);
    chk("never_both", both_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mcpu_uart_rx.md
Name: mcpu_uart_rx

Overview:
- UART receiver (8N1, LSB first) for the core's serial input, the receive end of the link the core transmits on.
- Sits between the external uart_rx pin and the core's byte-level consumer (MMIO UART register or a bench checker decoding uart_tx).
- Oversamples the line with a per-bit clock divider and delivers each received byte through a valid/ready holding register.
- Reports framing errors and overruns.

Parameters:
CLKS_PER_BIT, 1085, core clocks per bit period (125 MHz / 115200 baud); legal range >= 4.
SYNC_STAGES, 2, flip-flops in the input synchronizer; legal range >= 2.

Ports:
clkrst_core_clk  input  1  core clock; all logic on rising edge.
clkrst_core_rst  input  1  synchronous, active-high reset.
uart_rx  input  1  asynchronous serial line; idles high.
rx_data  output  8  received byte; stable while rx_valid=1.
rx_valid  output  1  byte available in the holding register.
rx_ready  input  1  consumer accepts; a transfer occurs on an edge where rx_valid && rx_ready.
rx_frame_err  output  1  one-cycle pulse: stop bit sampled low.
rx_overrun  output  1  one-cycle pulse: a byte completed while the holding register was full and not being drained; the new byte is dropped.
rx_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (synchronous, any state, mid-frame included):
  - state=IDLE, bit counter=0, clock counter=0, shift register=0.
  - Synchronizer flops preset to 1.
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0.
- Synchronizer: uart_rx passes through SYNC_STAGES flops. The FSM uses only the synchronized value, rxs.
- Clock counter: width clog2(CLKS_PER_BIT). Cleared on every state change. "Tick" means counter == CLKS_PER_BIT-1; on a tick the counter wraps to 0.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: if rxs=0, go to START with the counter cleared.
  - START: at counter == CLKS_PER_BIT/2 - 1 (integer division, mid-bit):
    - rxs=0: go to DATA, bit index=0, counter cleared.
    - rxs=1: glitch; return to IDLE with no outputs.
  - DATA: on each tick, shift rxs into bit [index] (LSB first) and increment index. After the tick that samples bit 7, go to STOP.
  - STOP: on a tick, sample rxs.
    - rxs=1: byte complete; return to IDLE. The next start bit may be accepted from the following cycle, so back-to-back frames with a single stop bit are received.
    - rxs=0: pulse rx_frame_err, discard the byte, go to WAIT_IDLE.
  - WAIT_IDLE: remain until rxs=1, then go to IDLE. A held-low or break line never produces bytes or repeated errors.
- Sampling points: every data and stop bit is sampled at its mid-point, (k+1.5)*CLKS_PER_BIT after the synchronized falling edge, ±1 cycle.
- Byte completion, on the stop-sample edge:
  - rx_valid=0, or rx_ready=1 on that same edge: load rx_data and set rx_valid=1 on the next cycle. A simultaneous drain and load gives no overrun and no bubble.
  - Otherwise: rx_data keeps the old byte, rx_valid stays 1, and rx_overrun pulses for one cycle.
- Handshake:
  - rx_valid, once set, stays high until an edge with rx_ready=1; it then clears unless a new byte loads on the same edge.
  - rx_ready while rx_valid=0 has no effect.
  - rx_data must not change while rx_valid=1 except on a transfer edge.
- Latency: rx_valid rises SYNC_STAGES + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1) after the uart_rx falling edge of the start bit.
- rx_frame_err and rx_overrun are never asserted in the same cycle. Both are 0 at all other times.

Test Plan (CLKS_PER_BIT=8 unless noted):
1. Release reset with uart_rx=1 held for 500 cycles -> rx_valid, rx_busy, rx_frame_err and rx_overrun all remain 0.
2. Send frame 0xA5 with rx_ready=1 -> exactly one rx_valid cycle, rx_data=0xA5, rise at cycle 2+4+72+1 (±1) after the start edge. Then send 0x00 and 0xFF back-to-back -> 0x00 then 0xFF received.
3. Pulse uart_rx low for 2 cycles, then high -> no rx_valid, rx_busy returns to 0 within 6 cycles. A following 0x5A frame is received correctly.
4. Frame 0x3C with the stop bit low, line then held low 40 cycles -> a single rx_frame_err pulse, no rx_valid, rx_busy stays high throughout. Line high, then 0x55 -> only 0x55 received.
5. rx_ready=0; send 0x11 then 0x22 -> rx_data=0x11 held, one rx_overrun pulse at the 0x22 stop sample. Raise rx_ready -> 0x11 transferred, rx_valid falls. Separately, with rx_valid=1, assert rx_ready on the exact completion edge of the next byte -> no overrun, rx_valid stays 1 with the new data.
6. Assert reset during DATA bit 3 of a frame -> all outputs 0 on the next cycle. After release with the line idle, a full frame 0xC3 is received correctly. Repeat test 2 with CLKS_PER_BIT=1085 for 0x7E.
